// File: rtl/prim_sum_window_pkg.sv
// Shared types and helpers for the windowed sum accumulator.
// State encoding and saturating-add sizing live here.
package prim_sum_window_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Width needed to hold a + b without loss.
  function automatic int sat_add_width(int a, int b);
    return ((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/prim_sat_add.sv
// Saturating adder: AccWidth + zero-extended Width -> AccWidth.
// Clamps at all-ones and flags the clamp.
module prim_sat_add
  import prim_sum_window_pkg::*;
#(
  parameter int Width    = 8,
  parameter int AccWidth = 16
) (
  input  logic [AccWidth-1:0] a,
  input  logic [Width-1:0]    b,
  output logic [AccWidth-1:0] sum,
  output logic                ovf
);

  localparam int SumW = sat_add_width(AccWidth, Width);

  logic [SumW-1:0] full;

  // Full-width add, then clamp on any carry beyond AccWidth.
  always_comb begin
    full = SumW'(a) + SumW'(b);
    ovf  = |full[SumW-1:AccWidth];
    sum  = ovf ? '1 : full[AccWidth-1:0];
  end

endmodule

// File: rtl/prim_sum_window.sv
// Windowed saturating accumulator of per-cycle tree sums.
// Emits total, valid count and threshold flag per window.
module prim_sum_window
  import prim_sum_window_pkg::*;
#(
  parameter int Width    = 8,
  parameter int AccWidth = 16,
  parameter int CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    sum_value_i,
  input  logic                sum_valid_i,
  input  logic                en_i,
  input  logic                clear_i,
  input  logic [CntWidth-1:0] window_len_i,
  input  logic [AccWidth-1:0] threshold_i,
  output logic [AccWidth-1:0] result_o,
  output logic [CntWidth-1:0] nvalid_o,
  output logic                sat_o,
  output logic                over_thresh_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                drop_o
);

  state_e state_q, state_d;

  logic [CntWidth-1:0] len_q;
  logic [CntWidth-1:0] cnt_q;
  logic [AccWidth-1:0] acc_q;
  logic [CntWidth-1:0] nv_q;
  logic                sat_q;

  logic [AccWidth-1:0] res_q;
  logic [CntWidth-1:0] nvalid_q;
  logic                res_sat_q;
  logic                over_q;
  logic                rvalid_q;
  logic                drop_q;

  logic [Width-1:0]    add_val;
  logic [AccWidth-1:0] acc_next;
  logic                add_ovf;
  logic [CntWidth-1:0] nv_next;
  logic                sat_next;
  logic [CntWidth-1:0] len_eff;
  logic                start;
  logic                win_end;
  logic                pop;
  logic                load;

  assign add_val = sum_valid_i ? sum_value_i : '0;

  prim_sat_add #(
    .Width    (Width),
    .AccWidth (AccWidth)
  ) u_add (
    .a   (acc_q),
    .b   (add_val),
    .sum (acc_next),
    .ovf (add_ovf)
  );

  // Per-cycle sample bookkeeping and control decode.
  always_comb begin
    nv_next  = nv_q;
    if (sum_valid_i && (nv_q != '1)) begin
      nv_next = nv_q + CntWidth'(1);
    end
    sat_next = sat_q | (sum_valid_i & add_ovf);
    len_eff  = (window_len_i == '0) ? CntWidth'(1)
                                    : window_len_i;
    pop      = rvalid_q & result_ready_i;
    load     = ~rvalid_q | result_ready_i;
  end

  // Next-state logic; clear always forces IDLE.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    win_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = ACCUM;
          start   = 1'b1;
        end
      end
      ACCUM: begin
        if (cnt_q == len_q - CntWidth'(1)) begin
          win_end = 1'b1;
          state_d = en_i ? ACCUM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      start   = 1'b0;
      win_end = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window counters, accumulator and output slot.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      nv_q      <= '0;
      sat_q     <= 1'b0;
      res_q     <= '0;
      nvalid_q  <= '0;
      res_sat_q <= 1'b0;
      over_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (pop) begin
        rvalid_q <= 1'b0;
      end
      if (start) begin
        len_q <= len_eff;
        cnt_q <= '0;
        acc_q <= '0;
        nv_q  <= '0;
        sat_q <= 1'b0;
      end
      if (state_q == ACCUM) begin
        if (win_end) begin
          cnt_q <= '0;
          acc_q <= '0;
          nv_q  <= '0;
          sat_q <= 1'b0;
          if (en_i) begin
            len_q <= len_eff;
          end
          if (load) begin
            res_q     <= acc_next;
            nvalid_q  <= nv_next;
            res_sat_q <= sat_next;
            over_q    <= (acc_next >= threshold_i);
            rvalid_q  <= 1'b1;
          end else begin
            drop_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + CntWidth'(1);
          acc_q <= acc_next;
          nv_q  <= nv_next;
          sat_q <= sat_next;
        end
      end
    end
  end

  assign result_o       = res_q;
  assign nvalid_o       = nvalid_q;
  assign sat_o          = res_sat_q;
  assign over_thresh_o  = over_q;
  assign result_valid_o = rvalid_q;
  assign drop_o         = drop_q;

endmodule

// File: tb/tb_prim_sum_window.sv
// Directed bench for prim_sum_window.
// Hand-computed expectations, immediate assertions.
module tb_prim_sum_window;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sum_value;
  logic       sum_valid;
  logic       en;
  logic       clear;
  logic [7:0] window_len;
  logic [7:0] threshold;
  logic [7:0] result;
  logic [7:0] nvalid;
  logic       sat;
  logic       over_thresh;
  logic       result_valid;
  logic       result_ready;
  logic       drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prim_sum_window #(
    .Width    (8),
    .AccWidth (8),
    .CntWidth (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sum_value_i    (sum_value),
    .sum_valid_i    (sum_valid),
    .en_i           (en),
    .clear_i        (clear),
    .window_len_i   (window_len),
    .threshold_i    (threshold),
    .result_o       (result),
    .nvalid_o       (nvalid),
    .sat_o          (sat),
    .over_thresh_o  (over_thresh),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .drop_o         (drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag,
                          input int r, input int n,
                          input logic s, input logic o);
    chk({tag, "_valid"}, 32'(result_valid), 1);
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_nvalid"}, 32'(nvalid), 32'(n));
    chk({tag, "_sat"}, 32'(sat), 32'(s));
    chk({tag, "_over"}, 32'(over_thresh), 32'(o));
  endtask

  initial begin
    rst          = 1'b1;
    sum_value    = '0;
    sum_valid    = 1'b0;
    en           = 1'b0;
    clear        = 1'b0;
    window_len   = '0;
    threshold    = '0;
    result_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_nvalid", 32'(nvalid), 0);
    chk("rst_drop", 32'(drop), 0);
    rst = 1'b0;
    tick();

    // Saturation: 200*3 clamps to 255
    window_len = 8'd3;
    threshold  = 8'd255;
    sum_value  = 8'd200;
    sum_valid  = 1'b1;
    en         = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    chk_slot("sat", 255, 3, 1'b1, 1'b1);
    tick();
    chk("sat_pop", 32'(result_valid), 0);

    // Basic window 1+2+3+4
    window_len = 8'd4;
    threshold  = 8'd11;
    en         = 1'b1;
    tick();
    sum_value = 8'd1;
    tick();
    sum_value = 8'd2;
    tick();
    sum_value = 8'd3;
    tick();
    chk("basic_early", 32'(result_valid), 0);
    sum_value = 8'd4;
    en        = 1'b0;
    tick();
    chk_slot("basic", 10, 4, 1'b0, 1'b0);
    tick();
    chk("basic_one_cycle", 32'(result_valid), 0);

    // Invalid gaps: 5 on cycles 0 and 2 only
    threshold = 8'd10;
    sum_value = 8'd5;
    en        = 1'b1;
    tick();
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    tick();
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    en        = 1'b0;
    tick();
    chk_slot("gaps", 10, 2, 1'b0, 1'b1);
    tick();

    // Zero length acts as one cycle per window
    window_len = 8'd0;
    threshold  = 8'd8;
    sum_valid  = 1'b1;
    en         = 1'b1;
    tick();
    sum_value = 8'd7;
    tick();
    chk_slot("len0_a", 7, 1, 1'b0, 1'b0);
    sum_value = 8'd9;
    en        = 1'b0;
    tick();
    chk_slot("len0_b", 9, 1, 1'b0, 1'b1);
    tick();
    chk("len0_pop", 32'(result_valid), 0);

    // Backpressure with drop, then pop+load
    window_len   = 8'd2;
    threshold    = 8'd100;
    result_ready = 1'b0;
    en           = 1'b1;
    tick();
    sum_value = 8'd1;
    tick();
    sum_value = 8'd2;
    tick();
    chk_slot("bp_first", 3, 2, 1'b0, 1'b0);
    sum_value = 8'd3;
    tick();
    chk("bp_hold", 32'(result), 3);
    sum_value = 8'd4;
    tick();
    chk("bp_drop", 32'(drop), 1);
    chk("bp_drop_hold", 32'(result), 3);
    sum_value = 8'd5;
    tick();
    chk("bp_drop_pulse", 32'(drop), 0);
    result_ready = 1'b1;
    sum_value    = 8'd6;
    en           = 1'b0;
    tick();
    chk_slot("bp_popload", 11, 2, 1'b0, 1'b0);
    chk("bp_no_drop", 32'(drop), 0);
    tick();
    chk("bp_pop", 32'(result_valid), 0);

    // Clear mid-window with full slot
    window_len   = 8'd4;
    result_ready = 1'b0;
    sum_value    = 8'd1;
    en           = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("clr_full", 32'(result_valid), 1);
    sum_value = 8'd2;
    tick();
    tick();
    clear = 1'b1;
    tick();
    chk("clr_valid", 32'(result_valid), 0);
    chk("clr_drop", 32'(drop), 0);
    clear        = 1'b0;
    result_ready = 1'b1;
    sum_value    = 8'd3;
    tick();
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("clr_restart", 32'(result), 12);
    chk("clr_nvalid", 32'(nvalid), 4);
    tick();

    // Enable dropped mid-window
    sum_value = 8'd1;
    en        = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
    chk("endrop_result", 32'(result), 4);
    chk("endrop_valid", 32'(result_valid), 1);
    for (int i = 0; i < 6; i++) tick();
    chk("endrop_idle", 32'(result_valid), 0);

    // Reset mid-window
    window_len   = 8'd2;
    threshold    = 8'd5;
    result_ready = 1'b0;
    sum_value    = 8'd9;
    en           = 1'b1;
    tick();
    tick();
    tick();
    chk_slot("prerst", 18, 2, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_valid", 32'(result_valid), 0);
    chk("rst2_result", 32'(result), 0);
    chk("rst2_nvalid", 32'(nvalid), 0);
    chk("rst2_over", 32'(over_thresh), 0);
    chk("rst2_sat", 32'(sat), 0);
    chk("rst2_drop", 32'(drop), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prim_sum_window.md
# prim_sum_window

Sequential windowed accumulator placed directly downstream of the combinational sum tree. Each cycle it takes the tree's `sum_value`/`sum_valid` pair and accumulates the valid sums over a programmable window of N clock cycles, with saturation. At the end of each window it registers the total, a valid-sample count and a threshold flag into a single-entry output slot with a valid/ready handshake. Typical consumers are rate or occupancy monitors that need "events per window" rather than a per-cycle sum.

## Interface
Parameters:
- `Width`, 8: width of the incoming per-cycle sum.
- `AccWidth`, 16: accumulator and result width; must be >= `Width`.
- `CntWidth`, 8: width of the window length and of the sample counters.

Ports:
- `clk_i`, input, 1: clock. One clock domain only.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `sum_value_i`, input, `Width`: per-cycle sum from the tree.
- `sum_valid_i`, input, 1: `sum_value_i` is meaningful this cycle.
- `en_i`, input, 1: level enable; starts and continues windowing.
- `clear_i`, input, 1: synchronous abort of the current window and the output slot.
- `window_len_i`, input, `CntWidth`: cycles per window; 0 is treated as 1.
- `threshold_i`, input, `AccWidth`: compare value for `over_thresh_o`.
- `result_o`, output, `AccWidth`: window total.
- `nvalid_o`, output, `CntWidth`: number of cycles in the window with `sum_valid_i`=1.
- `sat_o`, output, 1: the accumulator saturated during this window.
- `over_thresh_o`, output, 1: `result_o >= threshold_i`, with `threshold_i` sampled at window end.
- `result_valid_o`, output, 1: output slot is full.
- `result_ready_i`, input, 1: consumer accepts the slot.
- `drop_o`, output, 1: one-cycle pulse when a completed window is discarded because the slot is busy.

## Operation
- **FSM states:** IDLE and ACCUM.
  - IDLE → ACCUM when `en_i`=1. On that transition, `window_len_i` is latched (0→1), `cnt`=0, `acc`=0 and `nv`=0.
  - ACCUM → IDLE at window end if `en_i`=0. `en_i` falling mid-window does not truncate the window.
  - ACCUM → ACCUM at window end if `en_i`=1. The next window starts the following cycle with no gap, and `window_len_i` is re-latched.
- **Per ACCUM cycle:**
  - `cnt++`.
  - If `sum_valid_i`=1: `acc = sat(acc + zero-extended sum_value_i)` and `nv++`. `nv` saturates at all-ones.
  - If the addition saturates, the sticky `sat` bit is set.
  - Invalid cycles still count toward the window length.
- **Window end:** the cycle where `cnt == len-1`. That cycle's sample is included in the final total (`acc_next`).
  - Slot empty, or `result_valid_o && result_ready_i` in the same cycle: load `result_o`, `nvalid_o`, `sat_o`, `over_thresh_o`; `result_valid_o`=1 next cycle.
  - Otherwise: discard the result, pulse `drop_o` next cycle; slot contents are unchanged.
  - In both cases `acc`, `nv`, `cnt` and `sat` are reset for the next window.
- **Handshake:**
  - The slot clears on `result_valid_o && result_ready_i` unless a new load happens in the same cycle.
  - Outputs are stable while `result_valid_o`=1 and `result_ready_i`=0.
- **Saturation:** `acc` clamps at 2^`AccWidth`-1. No wrap-around is permitted.
- **`clear_i`:** highest priority, overrides `en_i`, window end and handshake.
  - FSM → IDLE; `acc`/`nv`/`cnt`/`sat` = 0; `result_valid_o`=0; no `drop_o`.
  - If `en_i` is still 1, ACCUM re-enters the next cycle.
- **Reset values:** all outputs 0, FSM IDLE, all internal registers 0.

## Timing
- Window of N cycles sampled in cycles t..t+N-1; `result_valid_o`=1 from cycle t+N.
- First sampled cycle is the one after `en_i` is seen high in IDLE, i.e. 1 cycle entry latency.
- `drop_o` is asserted in cycle t+N for exactly one cycle.
- Throughput: one result per N cycles. N=1 gives one result per cycle if `result_ready_i` is held at 1.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- **Package `prim_sum_window_pkg`:** state enum typedef (IDLE, ACCUM) and a saturating-add width helper function.
- **Sub-module `prim_sat_add`:** parameterised saturating adder (`AccWidth` + `Width` → `AccWidth`, plus an overflow flag). Instantiated once.
- **Top level contains:** the FSM, the counters and the output slot.

## Test plan
- **Basic window:** `window_len_i`=4, `sum_valid_i`=1, values 1,2,3,4, `result_ready_i`=1 → `result_o`=10, `nvalid_o`=4, one `result_valid_o` cycle at t+4.
- **Invalid gaps and zero length:** `window_len_i`=4, valid pattern 1,0,1,0 with value 5 each cycle → `result_o`=10, `nvalid_o`=2. `window_len_i`=0 → each cycle yields its own result.
- **Saturation:** `AccWidth`=8, `window_len_i`=3, value 200 each cycle → `result_o`=255, `sat_o`=1. `over_thresh_o`=1 when `threshold_i`=255.
- **Backpressure:** `window_len_i`=2, `result_ready_i`=0 for 4 cycles → first result held stable, second window pulses `drop_o`. Pop and load in the same cycle → no drop, new result appears next cycle.
- **Abort and enable:** `clear_i` at cycle 2 of a 4-cycle window with slot full → `result_valid_o`=0 next cycle and the partial sum is lost. `en_i` dropped mid-window → window completes, then FSM goes IDLE.
- **Reset:** `rst_i` mid-window → all outputs 0 next cycle.
